arith_share_arbiter: RTL and testbench

//  Shares one arithmetic datapath (adder_rca / adder_cla / multiplier behind dut_wrapper)

---
 rtl/arith_share_arbiter.sv | 132 +++++++++++++
 tb/tb_arith_share_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_share_arbiter.sv
// Round-robin arbiter sharing one arithmetic datapath between NREQ requesters.
// One operation in flight; fixed-latency result capture; tagged valid/ready response.
module arith_share_arbiter #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int DP_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        dp_a,
    output logic [WIDTH-1:0]        dp_b,
    output logic                    dp_op,
    output logic                    dp_start,
    input  logic [2*WIDTH-1:0]      dp_result,
    output logic                    resp_valid,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
    output logic [2*WIDTH-1:0]      resp_result,
    input  logic                    resp_ready,
    output logic                    busy
);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic                op_q, op_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [2*WIDTH-1:0]  res_q, res_d;

    logic                found;
    logic [IDW-1:0]      win;
    logic [IDW:0]        sum;
    logic [IDW:0]        id_inc;

    // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        res_d     = res_q;
        req_ready = '0;
        id_inc    = {1'b0, id_q} + (IDW+1)'(1);
        if (id_inc >= (IDW+1)'(NREQ)) id_inc = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    a_d     = req_a[win*WIDTH +: WIDTH];
                    b_d     = req_b[win*WIDTH +: WIDTH];
                    op_d    = req_op[win];
                    id_d    = win;
                    cnt_d   = CNTW'(DP_LATENCY);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    // Add results drop the carry-out; only mul uses the upper half.
                    res_d   = op_q ? dp_result : {{WIDTH{1'b0}}, dp_result[WIDTH-1:0]};
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rr_ptr_d = id_inc[IDW-1:0];
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            id_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            res_q    <= res_d;
        end
    end

    assign dp_a        = a_q;
    assign dp_b        = b_q;
    assign dp_op       = op_q;
    assign dp_start    = (state_q == EXEC) && (cnt_q == CNTW'(DP_LATENCY));
    assign resp_valid  = (state_q == RESP);
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_arith_share_arbiter.sv
// Scoreboard bench for arith_share_arbiter with a registered stub datapath.
module tb_arith_share_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_op, req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [W-1:0]     dp_a, dp_b;
    logic             dp_op, dp_start;
    logic [2*W-1:0]   dp_result;
    logic             resp_valid, resp_ready, busy;
    logic [1:0]       resp_id;
    logic [2*W-1:0]   resp_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int id; int res;} exp_t;
    exp_t q[$];
    int   glog_id[$];
    int   glog_cyc[$];
    int   m_ptr = 0;
    bit   m_busy = 0;

    arith_share_arbiter #(.WIDTH(W), .NREQ(N), .DP_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_start(dp_start),
        .dp_result(dp_result), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_result(resp_result), .resp_ready(resp_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub datapath: full-width add or multiply, registered once.
    always @(posedge clk)
        dp_result <= dp_op ? (16'(dp_a) * 16'(dp_b)) : (16'(dp_a) + 16'(dp_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: reference model of the arbitration plus the response scoreboard.
    initial begin : monitor
        int   widx, g, ra, rb, pa, pb, pop;
        bit   prev_hold, prev_rv;
        logic [N-1:0] exp_ready;
        logic [1:0]   h_id;
        logic [15:0]  h_res;
        exp_t e;
        g = -100; prev_hold = 0; prev_rv = 0; pa = 0; pb = 0; pop = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete(); m_busy = 0; m_ptr = 0; g = -100;
                prev_hold = 0; prev_rv = 0;
                continue;
            end
            exp_ready = '0; widx = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (widx < 0 && req_valid[(m_ptr + k) % N]) widx = (m_ptr + k) % N;
            if (widx >= 0) exp_ready[widx] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(m_busy));
            if (dp_start) begin
                chk("dp_start_lat", 32'(cyc - g), 32'd1);
                chk("dp_operands", {15'd0, dp_op, dp_a, dp_b}, {15'd0, pop[0], pa[7:0], pb[7:0]});
            end
            if (resp_valid && !prev_rv) chk("resp_lat", 32'(cyc - g), 32'(L + 1));
            if (prev_hold) begin
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_data", {14'd0, resp_id, resp_result}, {14'd0, h_id, h_res});
            end
            prev_hold = resp_valid && !resp_ready;
            prev_rv   = resp_valid;
            h_id = resp_id; h_res = resp_result;
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected actual=id%0d required=none", resp_id);
                end else begin
                    e = q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_result", 32'(resp_result), 32'(e.res));
                end
                m_ptr  = (int'(resp_id) + 1) % N;
                m_busy = 0;
            end
            if (widx >= 0) begin
                ra = int'(req_a[widx*W +: W]);
                rb = int'(req_b[widx*W +: W]);
                e.id  = widx;
                e.res = req_op[widx] ? ra * rb : (ra + rb) % 256;
                q.push_back(e);
                glog_id.push_back(widx);
                glog_cyc.push_back(cyc);
                g = cyc; pa = ra; pb = rb; pop = int'(req_op[widx]);
                m_busy = 1;
            end
        end
    end

    task automatic set_req(input int i, input bit v, input bit op, input int a, input int b);
        req_valid[i]       = v;
        req_op[i]          = op;
        req_a[i*W +: W]    = W'(a);
        req_b[i*W +: W]    = W'(b);
    endtask

    task automatic issue(input int i, input bit op, input int a, input int b);
        bit got;
        got = 0;
        set_req(i, 1'b1, op, a, b);
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i] && !reset) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout actual=none required=req%0d", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            if (q.size() == 0 && !m_busy) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin : stim
        int base;
        bit seen;
        reset = 1'b1; resp_ready = 1'b1;
        req_valid = '1; req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_start", 32'(dp_start), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = '0; reset = 1'b0;
        @(posedge clk); #1;

        // Add with carry-out discarded: 255 + 1 -> 0.
        set_req(1, 1'b1, 1'b0, 255, 1);
        #1 chk("grant_req1", 32'(req_ready), 32'b0010);
        issue(1, 1'b0, 255, 1);
        wait_drain();

        issue(0, 1'b1, 255, 255);
        wait_drain();

        // All requesters valid from a fresh pointer: order 0,1,2,3,0, 4 cycles apart.
        pulse_reset();
        glog_id.delete(); glog_cyc.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, i + 1, 3);
        for (int n = 0; n < 60 && glog_id.size() < 5; n++) @(posedge clk);
        #1 req_valid = '0;
        if (glog_id.size() < 5) begin
            checks++; errors++;
            $display("FAIL rr_timeout actual=%0d grants required=5", glog_id.size());
        end else begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(glog_id[k]), 32'(k % N));
            for (int k = 1; k < 5; k++) chk("rr_interval", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'(L + 2));
        end
        wait_drain();

        // Back-pressure in RESP while other requests wait.
        resp_ready = 1'b0;
        issue(2, 1'b1, 7, 9);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("bp_resp_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 40, 50);
        set_req(3, 1'b1, 1'b0, 100, 200);
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        base = glog_id.size();
        @(posedge clk); #1 resp_ready = 1'b1;
        for (int n = 0; n < 20 && glog_id.size() == base; n++) @(posedge clk);
        #1 req_valid = '0;
        if (glog_id.size() == base) begin
            checks++; errors++;
            $display("FAIL bp_next_timeout actual=none required=req3");
        end else chk("bp_next_grant", 32'(glog_id[base]), 32'd3);
        wait_drain();

        // Reset in the second EXEC cycle abandons the op.
        issue(1, 1'b0, 10, 20);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        issue(3, 1'b1, 12, 12);
        wait_drain();

        // Randomised traffic with random back-pressure.
        repeat (400) begin
            @(posedge clk); #1;
            req_valid  = N'($urandom);
            req_op     = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
                req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0; resp_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
